ifetch_unit: RTL and testbench



---
 rtl/ifetch_unit_pkg.sv | 15 +
 rtl/ifetch_unit_if.sv | 23 ++
 rtl/ifetch_unit_npc.sv | 28 ++
 rtl/ifetch_unit.sv | 99 +++++++++
 tb/tb_ifetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC select codes
// (common with the control decoder) and the fetch FSM state type.
package ifetch_unit_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StExec = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory req/ack fetch bus. The fetch unit is the master.
interface ifetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_unit_npc.sv
// Combinational next-PC calculator: sequential, PC-relative branch and
// pseudo-direct jump targets. All arithmetic wraps modulo 2^32.
module ifetch_unit_npc
    import ifetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] instr_i,
    input  logic [1:0]  npc_op_i,
    output logic [31:0] npc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] branch_off;

    assign pc_plus4_o = pc_i + 32'd4;
    assign branch_off = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

    always_comb begin
        npc_o = pc_plus4_o;
        case (npc_op_i)
            NPC_BRANCH: npc_o = pc_plus4_o + branch_off;
            NPC_JUMP:   npc_o = {pc_plus4_o[31:28], instr_i, 2'b00};
            // Reserved code falls back to the sequential path
            default:    npc_o = pc_plus4_o;
        endcase
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over
// req/ack, freezes it for the core until instr_done, then steps the PC.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                rstn,
    ifetch_unit_if.master       imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                instr_done,
    input  logic [1:0]          NPCOp,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic [31:0]         retired
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retired_q, retired_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [31:0]  npc;

    ifetch_unit_npc u_npc (
        .pc_i       (pc_q),
        .instr_i    (instr_q[25:0]),
        .npc_op_i   (NPCOp),
        .npc_o      (npc),
        .pc_plus4_o (pc_plus4)
    );

    // req/valid are registered alongside the state so they never glitch
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        req_d     = req_q;
        valid_d   = valid_q;
        case (state_q)
            StIdle: begin
                state_d = StReq;
                req_d   = 1'b1;
            end
            StReq: begin
                if (imem.imem_ack) begin
                    state_d = StExec;
                    instr_d = imem.imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            StExec: begin
                if (instr_done) begin
                    state_d   = StReq;
                    pc_d      = npc;
                    retired_d = retired_q + 32'd1;
                    req_d     = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'd0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, randomized
// fetch/execute traffic against an architectural PC model, reset corners.
module tb_ifetch_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_done;
    logic [1:0]  NPCOp;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    int checks;
    int failures;

    logic [31:0] m_pc;
    logic [31:0] m_ret;

    ifetch_unit_if imem_bus ();

    ifetch_unit #(
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_done  (instr_done),
        .NPCOp       (NPCOp),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [1:0]  op;
        int          lat;
        int          ddly;
        bit          stray;
        logic [31:0] npc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural next-PC rule written directly from the ISA arithmetic
    function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] w,
                                            input logic [1:0] op);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = $signed(w[15:0]);
        case (op)
            2'd1:    return seq + 32'(off * 4);
            2'd2:    return (seq & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
            default: return seq;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        imem_bus.imem_ack = 1'b0;
        instr_done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_retired", retired, 32'd0);
        rstn = 1'b1;
        check("idle_req", {31'b0, imem_bus.imem_req}, 32'd0);
        tick();
        check("first_req", {31'b0, imem_bus.imem_req}, 32'd1);
        check("first_addr", imem_bus.imem_addr, 32'h0000_3000);
        m_pc = 32'h0000_3000;
        m_ret = 32'd0;
    endtask

    // One full fetch/execute transaction; leaves the DUT back in REQ
    task automatic do_step(input logic [31:0] word, input logic [1:0] op, input int lat,
                           input int ddly, input bit stray);
        int n;
        n = 0;
        while (!imem_bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", {31'b0, imem_bus.imem_req}, 32'd1);
        check("fetch_addr", imem_bus.imem_addr, m_pc);
        for (int i = 0; i < lat; i++) begin
            instr_done = stray;
            imem_bus.imem_ack = 1'b0;
            tick();
            check("addr_hold", imem_bus.imem_addr, m_pc);
            check("req_hold", {31'b0, imem_bus.imem_req}, 32'd1);
            check("ret_hold", retired, m_ret);
        end
        instr_done = 1'b0;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = word;
        tick();
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = $urandom;
        check("valid_up", {31'b0, instr_valid}, 32'd1);
        check("instr_latch", instr, word);
        check("req_drop", {31'b0, imem_bus.imem_req}, 32'd0);
        for (int i = 0; i < ddly; i++) begin
            imem_bus.imem_ack = stray;
            tick();
            check("instr_frozen", instr, word);
            check("valid_hold", {31'b0, instr_valid}, 32'd1);
        end
        imem_bus.imem_ack = 1'b0;
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        instr_done = 1'b1;
        NPCOp = op;
        tick();
        instr_done = 1'b0;
        NPCOp = 2'($urandom);
        m_pc = ref_npc(m_pc, word, op);
        m_ret = m_ret + 32'd1;
        check("next_pc", pc, m_pc);
        check("retired", retired, m_ret);
        check("next_req", {31'b0, imem_bus.imem_req}, 32'd1);
        check("valid_down", {31'b0, instr_valid}, 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        instr_done = 1'b0;
        NPCOp = 2'b00;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = 32'd0;

        //            pc            word          op     lat ddly stray npc
        vecs[0]  = '{32'h0000_3000, 32'h2008_0005, 2'b00, 0, 0, 1'b0, 32'h0000_3004};
        vecs[1]  = '{32'h0000_3004, 32'h0000_0000, 2'b00, 1, 1, 1'b1, 32'h0000_3008};
        vecs[2]  = '{32'h0000_3008, 32'h1000_0010, 2'b11, 0, 2, 1'b0, 32'h0000_300C};
        vecs[3]  = '{32'h0000_300C, 32'h0000_0020, 2'b00, 2, 0, 1'b0, 32'h0000_3010};
        vecs[4]  = '{32'h0000_3010, 32'h1000_FFFE, 2'b01, 0, 0, 1'b0, 32'h0000_300C};
        vecs[5]  = '{32'h0000_300C, 32'h1000_0004, 2'b01, 1, 0, 1'b0, 32'h0000_3020};
        vecs[6]  = '{32'h0000_3020, 32'h0800_0C10, 2'b10, 0, 1, 1'b0, 32'h0000_3040};
        vecs[7]  = '{32'h0000_3040, 32'h0BFF_FFFF, 2'b10, 5, 0, 1'b1, 32'h0FFF_FFFC};
        vecs[8]  = '{32'h0FFF_FFFC, 32'h0000_0000, 2'b00, 0, 0, 1'b0, 32'h1000_0000};
        vecs[9]  = '{32'h1000_0000, 32'h0800_0001, 2'b10, 0, 0, 1'b0, 32'h1000_0004};
        vecs[10] = '{32'h1000_0004, 32'h1000_8000, 2'b01, 3, 2, 1'b1, 32'h0FFE_0008};
        vecs[11] = '{32'h0FFE_0008, 32'h0800_0C00, 2'b10, 0, 0, 1'b0, 32'h0000_3000};
        vecs[12] = '{32'h0000_3000, 32'h1000_F3FE, 2'b01, 0, 0, 1'b0, 32'hFFFF_FFFC};
        vecs[13] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 1, 1, 1'b0, 32'h0000_0000};
        vecs[14] = '{32'h0000_0000, 32'h0800_0C00, 2'b10, 0, 0, 1'b0, 32'h0000_3000};

        apply_reset();

        foreach (vecs[i]) begin
            check("tbl_pc_before", pc, vecs[i].pc);
            do_step(vecs[i].word, vecs[i].op, vecs[i].lat, vecs[i].ddly, vecs[i].stray);
            check("tbl_npc", pc, vecs[i].npc);
        end

        for (int i = 0; i < 40; i++) begin
            do_step($urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 1'($urandom));
        end

        // Reset in EXEC at pc 3008 with retired 2 and an ack in flight
        apply_reset();
        do_step(32'h2008_0005, 2'b00, 0, 0, 1'b0);
        do_step(32'h0000_0000, 2'b00, 0, 0, 1'b0);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("mid_valid", {31'b0, instr_valid}, 32'd1);
        check("mid_pc", pc, 32'h0000_3008);
        check("mid_retired", retired, 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("async_pc", pc, 32'h0000_3000);
        check("async_retired", retired, 32'd0);
        check("async_valid", {31'b0, instr_valid}, 32'd0);
        check("async_req", {31'b0, imem_bus.imem_req}, 32'd0);
        check("async_instr", instr, 32'd0);
        tick();
        check("ack_in_reset", instr, 32'd0);
        apply_reset();
        do_step(32'h1234_5678, 2'b00, 1, 0, 1'b0);
        check("post_reset_pc", pc, 32'h0000_3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
